// File: rtl/cla_seq_adder.sv
// Multi-cycle W-bit adder/subtractor that reuses one 8-bit carry-lookahead slice,
// processing one byte per clock from the LSB slice upward.

module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       g,
    output logic       p
);
    logic [7:0] gi;
    logic [7:0] pi;
    logic [7:0] c;

    always_comb begin
        gi = a & b;
        pi = a ^ b;
        c  = '0;
        c[0] = cin;
        for (int i = 0; i < 7; i++) begin
            c[i+1] = gi[i] | (pi[i] & c[i]);
        end
        s = pi ^ c;
        g = 1'b0;
        for (int i = 0; i < 8; i++) begin
            g = gi[i] | (pi[i] & g);
        end
        p = &pi;
    end
endmodule

module cla_seq_adder #(
    parameter int NSLICE = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                op_sub,
    input  logic [8*NSLICE-1:0] data_a,
    input  logic [8*NSLICE-1:0] data_b,
    output logic                busy,
    output logic                done,
    output logic [8*NSLICE-1:0] result,
    output logic                cout,
    output logic                overflow,
    output logic                zero,
    output logic [1:0]          state_dbg
);
    localparam int W  = 8 * NSLICE;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Handshake: start is sampled only in IDLE or DONE and then latches op_sub and
    // both operands; busy is high while slices run; done is a one-cycle pulse, and
    // result/flags stay valid from done until the next accepted start.

    logic [1:0]    state;
    logic [KW-1:0] k;
    logic          carry;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;

    logic [KW+2:0] base;
    logic [7:0]    slice_a;
    logic [7:0]    slice_b;
    logic [7:0]    slice_s;
    logic          slice_g;
    logic          slice_p;
    logic          carry_next;
    logic          last;

    always_comb begin
        base       = {k, 3'b000};
        slice_a    = opa[base +: 8];
        slice_b    = opb[base +: 8];
        carry_next = slice_g | (slice_p & carry);
        last       = (k == KW'(NSLICE - 1));
    end

    cla8 u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry),
        .s   (slice_s),
        .g   (slice_g),
        .p   (slice_p)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            carry    <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opa   <= data_a;
                        opb   <= data_b ^ {W{op_sub}};
                        carry <= op_sub;
                        k     <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result[base +: 8] <= slice_s;
                    carry             <= carry_next;
                    k                 <= k + 1'b1;
                    if (last) begin
                        // Carry into the MSB is recovered from the top sum bit.
                        cout     <= carry_next;
                        overflow <= (slice_a[7] ^ slice_b[7] ^ slice_s[7]) ^ carry_next;
                        zero     <= (result[W-9:0] == '0) && (slice_s == 8'h00);
                        k        <= '0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;
endmodule
